mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Round-robin arbiter that shares the single SPI memory transaction engine inside the memory top level between up to NREQ crypto-core requesters. It accepts one read/write command at a time, forwards it to the engine, and routes the byte streams between the granted requester and the engine. It signals completion, or abort on a progress-watchdog timeout, back to that requester.

## Interface
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 24, memory byte-address width
- TIMEOUT, 1024, cycles without engine progress before abort (fits 16 bits)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester command request, held until req_ready
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  start address, requester i at [i*ADDR_W +: ADDR_W]
- req_len  in  NREQ*8  byte count minus 1, requester i at [i*8 +: 8]
- req_ready  out  NREQ  one-cycle pulse, command of requester i taken
- req_done  out  NREQ  one-cycle pulse, transaction of i complete
- req_err  out  NREQ  one-cycle pulse, transaction of i aborted by watchdog
- req_wdata  in  NREQ*8  write bytes
- req_wvalid  in  NREQ  write byte valid
- req_wready  out  NREQ  write byte accepted
- req_rdata  out  8  read byte, shared bus
- req_rvalid  out  NREQ  read byte valid, granted requester only
- cmd_valid / cmd_ready  out / in  1  command handshake to engine
- cmd_we, cmd_addr, cmd_len  out  1, ADDR_W, 8  registered command fields
- eng_wdata, eng_wvalid / eng_wready  out, out / in  8, 1 / 1  write stream to engine
- eng_rdata, eng_rvalid  in  8, 1  read stream from engine
- eng_done  in  1  one-cycle end-of-transaction pulse from engine
- eng_abort  out  1  one-cycle pulse forcing engine to idle
- gnt_id  out  clog2(NREQ)  index of current owner
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, BUSY, FIN.
- IDLE: if any req_valid is high, select the first set bit searching from ptr upward with wrap. Register gnt_id and latch that requester's we/addr/len into the cmd_* fields. Pulse req_ready[gnt_id]. Go to ISSUE.
- ISSUE: cmd_valid = 1. On cmd_ready, go to BUSY. The watchdog does not run in ISSUE.
- BUSY: combinational mux on gnt_id only:
  - eng_wdata/eng_wvalid come from the granted requester.
  - req_wready[gnt_id] = eng_wready.
  - req_rvalid[gnt_id] = eng_rvalid.
  - req_rdata = eng_rdata.
  - All other requesters see wready = rvalid = 0.
- BUSY exit:
  - On eng_done: pulse req_done[gnt_id], go to FIN.
  - On watchdog reaching TIMEOUT-1: pulse eng_abort and req_err[gnt_id], go to FIN.
- Watchdog: a 16-bit counter that clears on BUSY entry and on every data beat (eng_wvalid&eng_wready, or eng_rvalid). It increments otherwise.
- FIN: set ptr = (gnt_id+1) mod NREQ, then go to IDLE. This state gives one dead cycle for fairness.
- Requester dropping req_valid after req_ready has no effect; the transaction runs to completion.
- Outside BUSY, all stream outputs are 0 and req_rdata is 0.
- Simultaneous eng_done and watchdog expiry: eng_done wins; no eng_abort, no req_err.
- Requests for a new transaction are only sampled in IDLE. A requester that is still valid in FIN waits for the next IDLE arbitration.

## Timing
- Reset: state IDLE, ptr 0, gnt_id 0, watchdog 0. All outputs are 0, including cmd_* fields, busy, and all pulses.
- Reset asserted mid-transaction: immediate return to the reset values. No eng_abort is issued, because the engine shares rst.
- req_valid high at edge t (IDLE): req_ready pulse and cmd_valid both high during cycle t+1. The earliest BUSY is cycle t+2, with cmd_ready high in t+1.
- eng_done in cycle b: req_done high in cycle b+1 (FIN), IDLE in b+2. The next grant's req_ready is in b+3 at the earliest.
- Minimum back-to-back period is 4 cycles plus engine time.
- Watchdog: with no beats for TIMEOUT consecutive BUSY cycles, eng_abort and req_err rise on the next edge.
- cmd_* fields are stable from ISSUE entry until FIN.

## Test plan
- Single read: req0 read, addr 0x000100, len 3, engine returns 0xA1,0xB2,0xC3,0xD4. Required: req_ready[0] one cycle after the request, cmd_addr 0x000100, cmd_len 3, cmd_we 0, four req_rvalid[0] beats with those bytes, then req_done[0] and busy low 2 cycles after eng_done.
- Round robin: all three request continuously with ptr=0. Required: grant order 0,1,2,0. No requester is granted twice while another waits.
- Write routing: req2 write, len 1, bytes 0x5A,0x3C, engine eng_wready toggles. Required: eng_wdata follows req2, req_wready[2] mirrors eng_wready, req_wready[0] and req_wready[1] stay 0.
- Watchdog: TIMEOUT=8, engine stalls in BUSY. Required: eng_abort and req_err[gnt] pulse after exactly 8 idle cycles. No req_done. ptr advances.
- Done vs timeout tie: eng_done coincides with expiry. Required: req_done only, no eng_abort.
- Reset mid-BUSY: assert rst during BUSY. Required: all outputs 0 in the same cycle, ptr back to 0, and a fresh req1 is granted normally after release.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one SPI memory transaction engine between NREQ requesters.
// One command at a time; routes byte streams to the owner and aborts on a progress watchdog.
module mem_req_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_we,
  input  logic [NREQ*ADDR_W-1:0]    req_addr,
  input  logic [NREQ*8-1:0]         req_len,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           req_done,
  output logic [NREQ-1:0]           req_err,
  input  logic [NREQ*8-1:0]         req_wdata,
  input  logic [NREQ-1:0]           req_wvalid,
  output logic [NREQ-1:0]           req_wready,
  output logic [7:0]                req_rdata,
  output logic [NREQ-1:0]           req_rvalid,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_we,
  output logic [ADDR_W-1:0]         cmd_addr,
  output logic [7:0]                cmd_len,
  output logic [7:0]                eng_wdata,
  output logic                      eng_wvalid,
  input  logic                      eng_wready,
  input  logic [7:0]                eng_rdata,
  input  logic                      eng_rvalid,
  input  logic                      eng_done,
  output logic                      eng_abort,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      busy
);

  localparam int ID_W = $clog2(NREQ);
  localparam int IW   = ID_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, FIN} state_t;

  state_t            state_r;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   gnt_id_r;
  logic [15:0]       wd_r;
  logic [NREQ-1:0]   req_ready_r;
  logic [NREQ-1:0]   req_done_r;
  logic [NREQ-1:0]   req_err_r;
  logic              cmd_valid_r;
  logic              cmd_we_r;
  logic [ADDR_W-1:0] cmd_addr_r;
  logic [7:0]        cmd_len_r;
  logic              eng_abort_r;
  logic              busy_r;

  logic [ID_W-1:0]   pick_s;
  logic              found_s;
  logic [IW-1:0]     idx_s;
  logic              in_busy_s;
  logic              wbeat_s;
  logic              beat_s;
  logic              expire_s;

  // Rotating priority search: scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx_s   = {1'b0, ptr_r} + IW'(i);
      idx_s   = (idx_s >= IW'(NREQ)) ? (idx_s - IW'(NREQ)) : idx_s;
      pick_s  = req_valid[idx_s[ID_W-1:0]] ? idx_s[ID_W-1:0] : pick_s;
      found_s = found_s | req_valid[idx_s[ID_W-1:0]];
    end
  end

  // Stream routing between the owner and the engine; everything is quiet outside BUSY.
  always_comb begin
    req_wready = '0;
    req_rvalid = '0;
    req_rdata  = 8'h00;
    eng_wdata  = 8'h00;
    eng_wvalid = 1'b0;
    in_busy_s  = (state_r == BUSY);
    if (in_busy_s) begin
      eng_wdata            = req_wdata[gnt_id_r * 8 +: 8];
      eng_wvalid           = req_wvalid[gnt_id_r];
      req_wready[gnt_id_r] = eng_wready;
      req_rvalid[gnt_id_r] = eng_rvalid;
      req_rdata            = eng_rdata;
    end else begin
      eng_wvalid = 1'b0;
    end
  end

  // Progress detection for the watchdog; eng_done takes priority over expiry.
  always_comb begin
    wbeat_s  = req_wvalid[gnt_id_r] & eng_wready;
    beat_s   = wbeat_s | eng_rvalid;
    expire_s = (wd_r == 16'(TIMEOUT - 1)) & ~beat_s & ~eng_done;
  end

  // Arbitration FSM with registered command fields and handshake pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      gnt_id_r    <= '0;
      wd_r        <= 16'h0000;
      req_ready_r <= '0;
      req_done_r  <= '0;
      req_err_r   <= '0;
      cmd_valid_r <= 1'b0;
      cmd_we_r    <= 1'b0;
      cmd_addr_r  <= '0;
      cmd_len_r   <= 8'h00;
      eng_abort_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      req_ready_r <= '0;
      req_done_r  <= '0;
      req_err_r   <= '0;
      eng_abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt_id_r            <= pick_s;
            cmd_we_r            <= req_we[pick_s];
            cmd_addr_r          <= req_addr[pick_s * ADDR_W +: ADDR_W];
            cmd_len_r           <= req_len[pick_s * 8 +: 8];
            req_ready_r[pick_s] <= 1'b1;
            cmd_valid_r         <= 1'b1;
            busy_r              <= 1'b1;
            state_r             <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_r <= 1'b0;
            wd_r        <= 16'h0000;
            state_r     <= BUSY;
          end else begin
            state_r <= ISSUE;
          end
        end
        BUSY: begin
          if (eng_done) begin
            req_done_r[gnt_id_r] <= 1'b1;
            state_r              <= FIN;
          end else if (expire_s) begin
            req_err_r[gnt_id_r] <= 1'b1;
            eng_abort_r         <= 1'b1;
            state_r             <= FIN;
          end else if (beat_s) begin
            wd_r <= 16'h0000;
          end else begin
            wd_r <= wd_r + 16'h0001;
          end
        end
        FIN: begin
          ptr_r   <= (gnt_id_r == ID_W'(NREQ - 1)) ? '0 : (gnt_id_r + 1'b1);
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r      <= 1'b0;
          cmd_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign req_done  = req_done_r;
  assign req_err   = req_err_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_we    = cmd_we_r;
  assign cmd_addr  = cmd_addr_r;
  assign cmd_len   = cmd_len_r;
  assign eng_abort = eng_abort_r;
  assign gnt_id    = gnt_id_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: grants, read bytes and engine write bytes
// are queued when stimulus is driven and checked when the DUT produces them.
module tb_mem_req_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*8-1:0] req_len = '0;
  logic [NREQ-1:0]   req_ready, req_done, req_err, req_wready, req_rvalid;
  logic [NREQ*8-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_wvalid = '0;
  logic [7:0]        req_rdata;
  logic              cmd_valid, cmd_we;
  logic              cmd_ready = 1'b0;
  logic [AW-1:0]     cmd_addr;
  logic [7:0]        cmd_len;
  logic [7:0]        eng_wdata;
  logic              eng_wvalid;
  logic              eng_wready = 1'b0;
  logic [7:0]        eng_rdata = 8'h00;
  logic              eng_rvalid = 1'b0;
  logic              eng_done = 1'b0;
  logic              eng_abort;
  logic [1:0]        gnt_id;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int gnt_q[$];
  logic [10:0] rd_q[$];
  logic [7:0]  wr_q[$];

  mem_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wready(req_wready),
    .req_rdata(req_rdata), .req_rvalid(req_rvalid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .eng_wdata(eng_wdata), .eng_wvalid(eng_wvalid), .eng_wready(eng_wready),
    .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid), .eng_done(eng_done),
    .eng_abort(eng_abort), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!cmd_valid && n < 20) begin
      step();
      n++;
    end
    chk("issue_wait", {31'd0, cmd_valid}, 32'd1);
  endtask

  task automatic serve(input int busy_cyc);
    wait_issue();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    repeat (busy_cyc) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cmdv"}, {31'd0, cmd_valid}, 32'd0);
    chk({tag, "_gnt"}, {30'd0, gnt_id}, 32'd0);
    chk({tag, "_cmd"}, {cmd_we, cmd_len, 23'd0} | {8'd0, cmd_addr}, 32'd0);
    chk({tag, "_pulses"}, {20'd0, eng_abort, req_ready, req_done, req_err, 2'd0}, 32'd0);
    chk({tag, "_stream"}, {19'd0, eng_wvalid, req_wready, req_rvalid, 1'b0}, 32'd0);
    chk({tag, "_data"}, {16'd0, req_rdata, eng_wdata}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    eng_rvalid = 1'b1; eng_rdata = 8'h77; eng_wready = 1'b1;
    req_wvalid = 3'b111; req_wdata = 24'hABCDEF;
    step();
    step();
    check_quiet("reset");
    eng_rvalid = 1'b0; eng_rdata = 8'h00; eng_wready = 1'b0;
    req_wvalid = '0; req_wdata = '0;
    rst = 1'b0;
    step();
  endtask

  // Output monitor: pops expected grants, read bytes and engine write bytes.
  always @(negedge clk) begin
    int e;
    logic [10:0] r;
    if (!rst) begin
      if (req_ready != '0) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", {29'd0, req_ready}, 32'd0);
        else begin
          e = gnt_q.pop_front();
          chk("gnt_order", {29'd0, req_ready}, 32'd1 << e);
          chk("gnt_id", {30'd0, gnt_id}, e);
        end
      end
      if (req_rvalid != '0) begin
        if (rd_q.size() == 0) chk("rd_unexpected", {21'd0, req_rvalid, req_rdata}, 32'd0);
        else begin
          r = rd_q.pop_front();
          chk("rd_beat", {21'd0, req_rvalid, req_rdata}, {21'd0, r});
        end
      end
      if (eng_wvalid && eng_wready) begin
        if (wr_q.size() == 0) chk("wr_unexpected", {24'd0, eng_wdata}, 32'd0);
        else chk("wr_beat", {24'd0, eng_wdata}, {24'd0, wr_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] rb [4];
    logic [7:0] wb [2];
    int k;
    int n;
    rb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    wb = '{8'h5A, 8'h3C};
    req_addr[1*AW +: AW] = 24'h123456;
    req_addr[2*AW +: AW] = 24'h00ABCD;

    do_reset();

    // Single read from requester 0
    gnt_q.push_back(0);
    req_valid = 3'b001; req_we = 3'b000;
    req_addr[0 +: AW] = 24'h000100; req_len[0 +: 8] = 8'd3;
    step();
    chk("rd_ready", {29'd0, req_ready}, 32'd1);
    chk("rd_cmdv", {31'd0, cmd_valid}, 32'd1);
    chk("rd_addr", {8'd0, cmd_addr}, 32'h000100);
    chk("rd_len", {24'd0, cmd_len}, 32'd3);
    chk("rd_we", {31'd0, cmd_we}, 32'd0);
    req_valid = '0; cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("rd_cmdv_drop", {31'd0, cmd_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back({3'b001, rb[i]});
      eng_rvalid = 1'b1; eng_rdata = rb[i];
      step();
    end
    eng_rvalid = 1'b0; eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("rd_done", {29'd0, req_done}, 32'd1);
    chk("rd_busy_fin", {31'd0, busy}, 32'd1);
    chk("rd_addr_fin", {8'd0, cmd_addr}, 32'h000100);
    step();
    chk("rd_busy_idle", {31'd0, busy}, 32'd0);
    chk("rd_done_pulse", {29'd0, req_done}, 32'd0);

    // Round robin from ptr = 0 with all requesters continuously valid
    do_reset();
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(2); gnt_q.push_back(0);
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) serve(1);
    req_valid = '0;
    step();
    step();

    // Write routing for requester 2 (ptr is now 1)
    gnt_q.push_back(2);
    req_valid = 3'b100; req_we = 3'b100; req_len[16 +: 8] = 8'd1;
    wait_issue();
    chk("wr_we", {31'd0, cmd_we}, 32'd1);
    chk("wr_len", {24'd0, cmd_len}, 32'd1);
    req_valid = '0; cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    k = 0; n = 0;
    while (k < 2 && n < 20) begin
      req_wdata[16 +: 8] = wb[k]; req_wvalid = 3'b100;
      eng_wready = ~eng_wready;
      #1;
      chk("wr_route", {31'd0, req_wready[2]}, {31'd0, eng_wready});
      chk("wr_other", {30'd0, req_wready[1:0]}, 32'd0);
      chk("wr_data", {24'd0, eng_wdata}, {24'd0, wb[k]});
      if (eng_wready) begin
        wr_q.push_back(wb[k]);
        k++;
      end
      step();
      n++;
    end
    req_wvalid = '0; eng_wready = 1'b0; req_we = '0; eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("wr_done", {29'd0, req_done}, 32'd4);
    step();

    // Watchdog expiry for requester 1 (ptr is now 0)
    gnt_q.push_back(1);
    req_valid = 3'b010;
    wait_issue();
    req_valid = '0; cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    n = 0;
    while (!eng_abort && n < 40) begin
      step();
      n++;
    end
    chk("wd_cycles", n, 32'd8);
    chk("wd_err", {29'd0, req_err}, 32'd2);
    chk("wd_nodone", {29'd0, req_done}, 32'd0);
    step();
    chk("wd_abort_pulse", {31'd0, eng_abort}, 32'd0);
    // ptr advanced to 2: requester 2 wins over 1
    gnt_q.push_back(2);
    req_valid = 3'b110;
    serve(1);
    req_valid = '0;
    step();

    // eng_done coincides with watchdog expiry (ptr is now 0)
    gnt_q.push_back(1);
    req_valid = 3'b010;
    wait_issue();
    req_valid = '0; cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    repeat (7) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("tie_done", {29'd0, req_done}, 32'd2);
    chk("tie_err", {29'd0, req_err}, 32'd0);
    chk("tie_abort", {31'd0, eng_abort}, 32'd0);
    step();

    // Reset in the middle of BUSY (ptr is now 2)
    gnt_q.push_back(1);
    req_valid = 3'b010;
    wait_issue();
    req_valid = '0; cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    eng_rvalid = 1'b1; eng_rdata = 8'hFF; rst = 1'b1;
    #1;
    check_quiet("midrst");
    eng_rvalid = 1'b0; eng_rdata = 8'h00;
    step();
    rst = 1'b0;
    step();
    // ptr back to 0: requester 0 wins over 2
    gnt_q.push_back(0);
    req_valid = 3'b101;
    serve(1);
    req_valid = '0;
    step();
    gnt_q.push_back(1);
    req_valid = 3'b010;
    serve(0);
    req_valid = '0;
    chk("post_done", {29'd0, req_done}, 32'd2);
    step();
    step();

    chk("gnt_q_empty", gnt_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
